// File: rtl/rps_match_scorer.sv
// rps_match_scorer: keeps the running score of a rock-paper-scissors match fed by
// the round judge and reports a registered result (first-to-WIN_TARGET or
// MAX_ROUNDS). Optional error abort is enabled by defining RPS_ERROR_ABORT_EN,
// which ends the match with a draw/aborted result once ERR_LIMIT error rounds
// have been seen.
module rps_match_scorer #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 9,
  parameter int ERR_LIMIT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       round_valid,
  output logic       round_ready,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       is_error,
  input  logic       is_A_win,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [3:0] round_cnt,
  output logic [3:0] error_cnt,
  output logic       busy,
  output logic       match_done,
  output logic [1:0] result
);

  localparam logic [3:0] WIN_T = 4'(WIN_TARGET);
  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);
`ifdef RPS_ERROR_ABORT_EN
  localparam logic [3:0] ERR_L = 4'(ERR_LIMIT);
`endif

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_A    = 2'b01;
  localparam logic [1:0] RES_B    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] score_a_next, score_b_next, round_cnt_next, error_cnt_next;
  logic [1:0] result_next;
  logic       accept;

  // A restart request takes priority over any round presented in the same cycle.
  assign round_ready = (state == PLAY) & ~start;
  assign accept      = round_valid & round_ready;

  // Status flags are pure decodes of the state register, so they change only on clock edges.
  assign busy       = (state == PLAY);
  assign match_done = (state == DONE);

  // Next-state and next-counter logic: classify the accepted round, then test end conditions on post-update values.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    state_next     = state;
    score_a_next   = score_a;
    score_b_next   = score_b;
    round_cnt_next = round_cnt;
    error_cnt_next = error_cnt;
    result_next    = result;

    if (start) begin
      state_next     = PLAY;
      score_a_next   = '0;
      score_b_next   = '0;
      round_cnt_next = '0;
      error_cnt_next = '0;
      result_next    = RES_NONE;
    end else if (accept) begin
      if (is_error) begin
        // Error rounds never touch the score; the count saturates rather than wrapping.
        if (error_cnt != 4'hF) begin
          error_cnt_next = error_cnt + 4'd1;
        end
`ifdef RPS_ERROR_ABORT_EN
        if (error_cnt_next == ERR_L) begin
          state_next  = DONE;
          result_next = RES_DRAW;
        end
`endif
      end else begin
        round_cnt_next = round_cnt + 4'd1;
        if (A != B) begin
          if (is_A_win) begin
            score_a_next = score_a + 4'd1;
          end else begin
            score_b_next = score_b + 4'd1;
          end
        end

        if (score_a_next == WIN_T) begin
          state_next  = DONE;
          result_next = RES_A;
        end else if (score_b_next == WIN_T) begin
          state_next  = DONE;
          result_next = RES_B;
        end else if (round_cnt_next == MAX_R) begin
          state_next  = DONE;
          result_next = RES_DRAW;
        end
      end
    end
  end

  // State and scoreboard registers; an asynchronous reset returns everything to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      score_a   <= '0;
      score_b   <= '0;
      round_cnt <= '0;
      error_cnt <= '0;
      result    <= RES_NONE;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
      state     <= state_next;
      score_a   <= score_a_next;
      score_b   <= score_b_next;
      round_cnt <= round_cnt_next;
      error_cnt <= error_cnt_next;
      result    <= result_next;
    end
  end

endmodule
